// File: rtl/game_pkg.sv
// rtl/game_pkg.sv - shared state encoding, score limit and LFSR constants for the game blocks
package game_pkg;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_RUN    = 2'd1;
  localparam logic [1:0] ST_UPDATE = 2'd2;
  localparam logic [1:0] ST_FREEZE = 2'd3;

  typedef enum logic [1:0] {
    IDLE   = ST_IDLE,
    RUN    = ST_RUN,
    UPDATE = ST_UPDATE,
    FREEZE = ST_FREEZE
  } state_e;

  localparam int SCREEN_W  = 640;
  localparam int SCORE_MAX = 9999;

  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  // Taps 16,14,13,11 expressed for a right-shifting register: bits 0,2,3,5.
  localparam logic [15:0] LFSR_TAPS = 16'h002D;

  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return {^(s & LFSR_TAPS), s[15:1]};
  endfunction

endpackage

// File: rtl/lfsr16.sv
// rtl/lfsr16.sv - free-running 16-bit Fibonacci LFSR used for pipe gap heights
module lfsr16
  import game_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  output logic [15:0] q
);

  logic [15:0] lfsr_q;

  always_ff @(posedge clk) begin
    if (reset) lfsr_q <= LFSR_SEED;
    else       lfsr_q <= lfsr_next(lfsr_q);
  end

  assign q = lfsr_q;

endmodule

// File: rtl/pipe_scheduler.sv
// rtl/pipe_scheduler.sv - time-multiplexed pipe slot stepper with respawn and scoring
module pipe_scheduler
  import game_pkg::*;
#(
  parameter int N_PIPES     = 3,
  parameter int X0          = 210,
  parameter int SPACING     = 200,
  parameter int STEP        = 2,
  parameter int PIPE_W      = 52,
  parameter int GAP_MIN     = 100,
  parameter int GAP_BITS    = 8,
  parameter int SCORE_MAX_P = SCORE_MAX
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    game_en,
  input  logic                    frame_tick,
  input  logic [9:0]              bird_x,
  output logic [10*N_PIPES-1:0]   pipe_x,
  output logic [10*N_PIPES-1:0]   pipe_y,
  output logic                    score_tick,
  output logic [13:0]             score,
  output logic [1:0]              state,
  output logic                    overrun
);

  localparam int              IW   = (N_PIPES > 1) ? $clog2(N_PIPES) : 1;
  localparam logic [IW-1:0]   LAST = IW'(N_PIPES - 1);
  localparam logic [9:0]      WRAP = 10'(N_PIPES * SPACING - STEP);

  state_e               state_q, state_d;
  logic [IW-1:0]        idx_q, idx_d;
  logic [9:0]           x_q [N_PIPES];
  logic [9:0]           y_q [N_PIPES];
  logic [N_PIPES-1:0]   scored_q;
  logic [13:0]          score_q;
  logic                 score_tick_q;
  logic                 overrun_q;

  logic [15:0]          lfsr;
  logic                 lfsr_unused;
  logic [9:0]           cur_x, x_new;
  logic [10:0]          diff;
  logic                 respawn, clear, service;

  lfsr16 u_lfsr (
    .clk   (clk),
    .reset (reset),
    .q     (lfsr)
  );

  assign lfsr_unused = ^lfsr[15:GAP_BITS];

  // Shared slot datapath: a borrow out of the subtractor marks a slot leaving the left edge.
  always_comb begin
    cur_x   = x_q[idx_q];
    diff    = {1'b0, cur_x} - 11'(STEP);
    respawn = diff[10];
    x_new   = respawn ? (cur_x + WRAP) : diff[9:0];
    clear   = !scored_q[idx_q] && !respawn &&
              (({1'b0, x_new} + 11'(PIPE_W)) < {1'b0, bird_x});
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    service = 1'b0;
    case (state_q)
      IDLE:   if (game_en) state_d = RUN;
      RUN: begin
        if (!game_en) begin
          state_d = FREEZE;
        end else if (frame_tick) begin
          state_d = UPDATE;
          idx_d   = '0;
        end
      end
      UPDATE: begin
        service = 1'b1;
        if (idx_q == LAST) state_d = game_en ? RUN : FREEZE;
        else               idx_d   = idx_q + 1'b1;
      end
      FREEZE: state_d = FREEZE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      idx_q        <= '0;
      scored_q     <= '0;
      score_q      <= '0;
      score_tick_q <= 1'b0;
      overrun_q    <= 1'b0;
      for (int i = 0; i < N_PIPES; i++) begin
        x_q[i] <= 10'(X0 + i * SPACING);
        y_q[i] <= 10'(GAP_MIN);
      end
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      score_tick_q <= service && clear;
      if (service) begin
        x_q[idx_q] <= x_new;
        if (respawn) begin
          y_q[idx_q]      <= 10'(GAP_MIN) + 10'(lfsr[GAP_BITS-1:0]);
          scored_q[idx_q] <= 1'b0;
        end else if (clear) begin
          scored_q[idx_q] <= 1'b1;
        end
        if (clear && (score_q != 14'(SCORE_MAX_P))) score_q <= score_q + 1'b1;
      end
      if ((state_q == UPDATE) && frame_tick) overrun_q <= 1'b1;
    end
  end

  for (genvar g = 0; g < N_PIPES; g++) begin : g_out
    assign pipe_x[10*g +: 10] = x_q[g];
    assign pipe_y[10*g +: 10] = y_q[g];
  end

  assign score_tick = score_tick_q;
  assign score      = score_q;
  assign state      = state_q;
  assign overrun    = overrun_q;

endmodule

// File: tb/tb_pipe_scheduler.sv
// tb/tb_pipe_scheduler.sv - table-driven and scoreboard bench for pipe_scheduler
module tb_pipe_scheduler;
  import game_pkg::*;

  logic        clk = 1'b0;
  logic        reset, game_en, frame_tick;
  logic [9:0]  bird_a, bird_b;
  logic [29:0] px_a, py_a, px_b, py_b;
  logic        tick_a, tick_b, ovr_a, ovr_b;
  logic [13:0] score_a, score_b;
  logic [1:0]  state_a, state_b;

  always #5 clk = ~clk;

  pipe_scheduler dut_a (
    .clk(clk), .reset(reset), .game_en(game_en), .frame_tick(frame_tick), .bird_x(bird_a),
    .pipe_x(px_a), .pipe_y(py_a), .score_tick(tick_a), .score(score_a), .state(state_a),
    .overrun(ovr_a)
  );

  pipe_scheduler #(.X0(1), .SCORE_MAX_P(3)) dut_b (
    .clk(clk), .reset(reset), .game_en(game_en), .frame_tick(frame_tick), .bird_x(bird_b),
    .pipe_x(px_b), .pipe_y(py_b), .score_tick(tick_b), .score(score_b), .state(state_b),
    .overrun(ovr_b)
  );

  int n_pass  = 0;
  int n_total = 0;

  int mx[2][3];
  bit ms[2][3];
  int msc[2];
  int mcap[2] = '{9999, 3};
  int tick_tot[2];

  int sb_q[$];

  typedef struct {
    int bird;
    int frames;
    int x0;
    int x1;
    int x2;
    int score;
  } vec_t;
  vec_t tbl[7];

  task automatic check(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  function automatic int dut_x(input int n, input int i);
    return (n == 0) ? int'(px_a[10*i +: 10]) : int'(px_b[10*i +: 10]);
  endfunction

  function automatic int dut_y(input int n, input int i);
    return (n == 0) ? int'(py_a[10*i +: 10]) : int'(py_b[10*i +: 10]);
  endfunction

  task automatic check_reset_values();
    check("rst_state_a", state_a, ST_IDLE);
    check("rst_state_b", state_b, ST_IDLE);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("rst_xa%0d", i), dut_x(0, i), 210 + 200 * i);
      check($sformatf("rst_xb%0d", i), dut_x(1, i), 1 + 200 * i);
      check($sformatf("rst_ya%0d", i), dut_y(0, i), 100);
    end
    check("rst_score_a", score_a, 0);
    check("rst_tick_a", tick_a, 0);
    check("rst_ovr_a", ovr_a, 0);
    check("rst_ovr_b", ovr_b, 0);
  endtask

  // Reference model of one pass; results are queued as
  // {ticks, score, x0, resp0, x1, resp1, x2, resp2} per instance.
  task automatic model_pass(input bit adv);
    int t;
    int rr[3];
    int bird;
    for (int n = 0; n < 2; n++) begin
      t = 0;
      bird = (n == 0) ? int'(bird_a) : int'(bird_b);
      for (int i = 0; i < 3; i++) begin
        rr[i] = 0;
        if (adv) begin
          if (mx[n][i] < 2) begin
            mx[n][i] = mx[n][i] + 598;
            ms[n][i] = 1'b0;
            rr[i] = 1;
          end else begin
            mx[n][i] = mx[n][i] - 2;
            if (!ms[n][i] && (mx[n][i] + 52 < bird)) begin
              ms[n][i] = 1'b1;
              t++;
              if (msc[n] < mcap[n]) msc[n]++;
            end
          end
        end
      end
      sb_q.push_back(t);
      sb_q.push_back(msc[n]);
      for (int i = 0; i < 3; i++) begin
        sb_q.push_back(mx[n][i]);
        sb_q.push_back(rr[i]);
      end
    end
  endtask

  task automatic run_frame(input bit hold2, input bit drop_en, input logic [1:0] exp_end, input bit adv);
    int seen[2];
    int y;
    logic [1:0] st_mid;
    seen[0] = 0;
    seen[1] = 0;
    @(negedge clk);
    frame_tick = 1'b1;
    model_pass(adv);
    @(posedge clk);
    @(negedge clk);
    if (!hold2) frame_tick = 1'b0;
    if (drop_en) game_en = 1'b0;
    st_mid = adv ? ST_UPDATE : ST_FREEZE;
    check("state_mid_a", state_a, st_mid);
    check("state_mid_b", state_b, st_mid);
    seen[0] += int'(tick_a);
    seen[1] += int'(tick_b);
    repeat (3) begin
      @(posedge clk);
      @(negedge clk);
      frame_tick = 1'b0;
      seen[0] += int'(tick_a);
      seen[1] += int'(tick_b);
    end
    check("state_end_a", state_a, exp_end);
    check("state_end_b", state_b, exp_end);
    for (int n = 0; n < 2; n++) begin
      tick_tot[n] += seen[n];
      check($sformatf("ticks%0d", n), seen[n], sb_q.pop_front());
      check($sformatf("score%0d", n), (n == 0) ? int'(score_a) : int'(score_b), sb_q.pop_front());
      for (int i = 0; i < 3; i++) begin
        check($sformatf("x%0d_%0d", n, i), dut_x(n, i), sb_q.pop_front());
        if (sb_q.pop_front() != 0) begin
          y = dut_y(n, i);
          check($sformatf("y_range%0d_%0d", n, i), int'(y >= 100 && y <= 355), 1);
        end
      end
    end
  endtask

  initial begin
    tbl[0] = '{0,    1,  208, 408, 608, 0};
    tbl[1] = '{0,    80, 48,  248, 448, 0};
    tbl[2] = '{100,  1,  46,  246, 446, 1};
    tbl[3] = '{100,  5,  36,  236, 436, 1};
    tbl[4] = '{100,  19, 598, 198, 398, 1};
    tbl[5] = '{1023, 1,  596, 196, 396, 4};
    tbl[6] = '{1023, 1,  594, 194, 394, 4};

    for (int i = 0; i < 3; i++) begin
      mx[0][i] = 210 + 200 * i;
      mx[1][i] = 1 + 200 * i;
      ms[0][i] = 1'b0;
      ms[1][i] = 1'b0;
    end
    msc = '{0, 0};
    tick_tot = '{0, 0};

    reset = 1'b1;
    game_en = 1'b0;
    frame_tick = 1'b0;
    bird_a = 10'd0;
    bird_b = 10'd1023;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_reset_values();
    reset = 1'b0;
    game_en = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("idle_to_run", state_a, ST_RUN);

    for (int r = 0; r < 7; r++) begin
      bird_a = 10'(tbl[r].bird);
      for (int f = 0; f < tbl[r].frames; f++) run_frame(1'b0, 1'b0, ST_RUN, 1'b1);
      check($sformatf("tbl%0d_x0", r), dut_x(0, 0), tbl[r].x0);
      check($sformatf("tbl%0d_x1", r), dut_x(0, 1), tbl[r].x1);
      check($sformatf("tbl%0d_x2", r), dut_x(0, 2), tbl[r].x2);
      check($sformatf("tbl%0d_score", r), score_a, tbl[r].score);
      if (r == 0) begin
        check("b_respawn_x0", dut_x(1, 0), 599);
        check("b_x1", dut_x(1, 1), 199);
        check("b_score_first", score_b, 2);
      end
    end
    check("b_sat_score", score_b, 3);
    check("b_tick_total", tick_tot[1], 4);
    check("b_final_x0", dut_x(1, 0), 385);
    check("b_final_x1", dut_x(1, 1), 585);
    check("b_final_x2", dut_x(1, 2), 185);
    check("a_tick_total", tick_tot[0], 4);

    check("ovr_before", ovr_a, 0);
    run_frame(1'b1, 1'b0, ST_RUN, 1'b1);
    check("ovr_after", ovr_a, 1);
    check("ovr_single_pass", dut_x(0, 0), 592);
    @(negedge clk);
    check("ovr_sticky", ovr_a, 1);

    run_frame(1'b0, 1'b1, ST_FREEZE, 1'b1);
    check("freeze_pass_done", dut_x(0, 0), 590);
    run_frame(1'b0, 1'b0, ST_FREEZE, 1'b0);
    run_frame(1'b0, 1'b0, ST_FREEZE, 1'b0);
    check("freeze_hold_x2", dut_x(0, 2), 390);

    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    game_en = 1'b1;
    @(posedge clk);
    @(negedge clk);
    frame_tick = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("mid_state_update", state_a, ST_UPDATE);
    @(posedge clk);
    @(negedge clk);
    frame_tick = 1'b0;
    check("mid_slot0_written", dut_x(0, 0), 208);
    check("mid_ovr_set", ovr_a, 1);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_reset_values();
    reset = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
